register_bank: RTL and testbench

Parametrised multi-register successor to the single bus register in the lab CPU datapath. Holds `p_reg_count` registers of `p_data_width` bits behind one shared bus port, with addressed read/write and in-place increment/decrement for PC/SP-style registers. Sticky wrap and error flags report arithmetic wrap-around and bus misuse. A second read port feeds the board display.

---
 rtl/register_bank.sv | 106 ++++++++++
 tb/tb_register_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Bank of p_reg_count bus registers with addressed write/read, a display read port and sticky err flag.
// Define REGISTER_BANK_INCDEC_EN to compile in increment/decrement and the sticky wrap flag.
module register_bank #(
  parameter int p_data_width = 16,
  parameter int p_reg_count  = 8,
  parameter int p_addr_width = 3
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic [p_addr_width-1:0] i_w_addr,
  input  logic [p_data_width-1:0] i_w_in,
  input  logic                    i_w_we,
  input  logic                    i_w_oe,
  input  logic                    i_w_inc,
  input  logic                    i_w_dec,
  input  logic                    i_w_clr_flags,
  input  logic [p_addr_width-1:0] i_w_disp_sel,
  output logic [p_data_width-1:0] o_w_out,
  output logic [p_data_width-1:0] o_w_disp_out,
  output logic                    o_w_zero,
  output logic                    o_w_wrap,
  output logic                    o_w_err
);

  localparam logic [p_addr_width:0] REG_COUNT = (p_addr_width + 1)'(p_reg_count);

  logic [p_data_width-1:0] regs [p_reg_count];
  logic                    err;
  logic                    addr_ok;
  logic                    disp_ok;
  logic                    inc_en;
  logic                    dec_en;
  logic [p_data_width-1:0] cur;
  logic [p_data_width-1:0] nxt;
  logic                    wr_en;
  logic                    set_wrap;
  logic                    set_err;

  assign addr_ok = ({1'b0, i_w_addr} < REG_COUNT);
  assign disp_ok = ({1'b0, i_w_disp_sel} < REG_COUNT);
  assign cur     = addr_ok ? regs[i_w_addr] : '0;

`ifdef REGISTER_BANK_INCDEC_EN
  assign inc_en = i_w_inc;
  assign dec_en = i_w_dec;
`else
  logic unused_incdec;
  assign inc_en        = 1'b0;
  assign dec_en        = 1'b0;
  assign unused_incdec = i_w_inc ^ i_w_dec ^ set_wrap;
`endif

  // One action per edge, resolved in priority order
  always_comb begin
    wr_en    = 1'b0;
    nxt      = cur;
    set_wrap = 1'b0;
    set_err  = 1'b0;
    if (i_w_we && i_w_oe) begin
      set_err = 1'b1;
    end else if (!addr_ok && (i_w_we || inc_en || dec_en)) begin
      set_err = 1'b1;
    end else if (i_w_we) begin
      wr_en = 1'b1;
      nxt   = i_w_in;
    end else if (inc_en && dec_en) begin
      wr_en = 1'b0;
    end else if (inc_en) begin
      wr_en    = 1'b1;
      nxt      = cur + 1'b1;
      set_wrap = &cur;
    end else if (dec_en) begin
      wr_en    = 1'b1;
      nxt      = cur - 1'b1;
      set_wrap = ~|cur;
    end
  end

  always_ff @(negedge i_w_clk) begin
    if (i_w_reset) begin
      for (int i = 0; i < p_reg_count; i++) regs[i] <= '0;
      err <= 1'b0;
    end else begin
      if (wr_en) regs[i_w_addr] <= nxt;
      err <= set_err | (err & ~i_w_clr_flags);
    end
  end

`ifdef REGISTER_BANK_INCDEC_EN
  logic wrap;
  always_ff @(negedge i_w_clk) begin
    if (i_w_reset) wrap <= 1'b0;
    else           wrap <= set_wrap | (wrap & ~i_w_clr_flags);
  end
  assign o_w_wrap = wrap;
`else
  assign o_w_wrap = 1'b0;
`endif

  // Bus output is zero unless driving, so several banks can be OR-combined
  assign o_w_out      = (i_w_oe && !i_w_we && addr_ok) ? cur : '0;
  assign o_w_disp_out = disp_ok ? regs[i_w_disp_sel] : '0;
  assign o_w_zero     = addr_ok && (cur == '0);
  assign o_w_err      = err;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: a main 8-register instance and a 6-register instance for range checks.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst, we, oe, inc, dec, clr;
  logic [2:0]  addr, dsel;
  logic [15:0] din;

  logic [15:0] m_out, m_disp, s_out, s_disp;
  logic        m_zero, m_wrap, m_err, s_zero, s_wrap, s_err;

  register_bank #(.p_data_width(16), .p_reg_count(8), .p_addr_width(3)) dut_m (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_addr(addr), .i_w_in(din), .i_w_we(we), .i_w_oe(oe),
    .i_w_inc(inc), .i_w_dec(dec), .i_w_clr_flags(clr), .i_w_disp_sel(dsel),
    .o_w_out(m_out), .o_w_disp_out(m_disp), .o_w_zero(m_zero), .o_w_wrap(m_wrap), .o_w_err(m_err)
  );

  register_bank #(.p_data_width(16), .p_reg_count(6), .p_addr_width(3)) dut_s (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_addr(addr), .i_w_in(din), .i_w_we(we), .i_w_oe(oe),
    .i_w_inc(inc), .i_w_dec(dec), .i_w_clr_flags(clr), .i_w_disp_sel(dsel),
    .o_w_out(s_out), .o_w_disp_out(s_disp), .o_w_zero(s_zero), .o_w_wrap(s_wrap), .o_w_err(s_err)
  );

  always #5 clk = ~clk;

  localparam int F_OUT = 0, F_DISP = 1, F_ZERO = 2, F_WRAP = 3, F_ERR = 4;

  typedef struct {
    int          dut;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    tests = 0;
  int    fails = 0;

`ifdef REGISTER_BANK_INCDEC_EN
  localparam bit INCDEC = 1'b1;
`else
  localparam bit INCDEC = 1'b0;
`endif

  function automatic logic [15:0] actual(input int dut, input int fld);
    logic [15:0] v;
    v = 'x;
    case (fld)
      F_OUT:  v = (dut == 0) ? m_out  : s_out;
      F_DISP: v = (dut == 0) ? m_disp : s_disp;
      F_ZERO: v = {15'd0, (dut == 0) ? m_zero : s_zero};
      F_WRAP: v = {15'd0, (dut == 0) ? m_wrap : s_wrap};
      F_ERR:  v = {15'd0, (dut == 0) ? m_err  : s_err};
      default: v = 'x;
    endcase
    return v;
  endfunction

  // Drive one cycle of inputs shortly after the rising edge; the falling edge applies them
  task automatic cyc(input logic r, input logic w, input logic o, input logic i, input logic d,
                     input logic c, input logic [2:0] a, input logic [15:0] di, input logic [2:0] ds);
    @(posedge clk);
    #1;
    rst = r; we = w; oe = o; inc = i; dec = d; clr = c; addr = a; din = di; dsel = ds;
  endtask

  task automatic chk(input int dut, input int fld, input logic [15:0] val, input string nm);
    exp_t e;
    e.dut = dut; e.fld = fld; e.val = val;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // Monitor: compare everything queued for this cycle just before the falling edge
  initial begin
    exp_t        e;
    string       nm;
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #4;
      while (q.size() > 0) begin
        e   = q.pop_front();
        nm  = nq.pop_front();
        act = actual(e.dut, e.fld);
        tests++;
        if (act !== e.val) begin
          fails++;
          $display("FAIL %s: got %h, expected %h", nm, act, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 0; oe = 0; inc = 0; dec = 0; clr = 0; addr = 0; din = 0; dsel = 0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 3'd0, 16'h0, 3'd0);
    for (int a = 0; a < 8; a++) begin
      cyc(0, 0, 1, 0, 0, 0, 3'(a), 16'h0, 3'(a));
      chk(0, F_OUT, 16'h0, $sformatf("reset_out_%0d", a));
      chk(0, F_ZERO, 16'h1, $sformatf("reset_zero_%0d", a));
      chk(0, F_DISP, 16'h0, $sformatf("reset_disp_%0d", a));
    end
    chk(0, F_WRAP, 16'h0, "reset_wrap");
    chk(0, F_ERR, 16'h0, "reset_err");

    // Write/read isolation
    cyc(0, 1, 0, 0, 0, 0, 3'd3, 16'hA5A5, 3'd0);
    cyc(0, 0, 1, 0, 0, 0, 3'd3, 16'h0, 3'd3);
    chk(0, F_OUT, 16'hA5A5, "read_r3");
    chk(0, F_DISP, 16'hA5A5, "disp_r3");
    chk(0, F_ZERO, 16'h0, "zero_r3");
    cyc(0, 0, 1, 0, 0, 0, 3'd2, 16'h0, 3'd2);
    chk(0, F_OUT, 16'h0, "read_r2");
    chk(0, F_ZERO, 16'h1, "zero_r2");
    cyc(0, 0, 0, 0, 0, 0, 3'd3, 16'h0, 3'd3);
    chk(0, F_OUT, 16'h0, "out_idle");
    chk(0, F_DISP, 16'hA5A5, "disp_idle");

    // Wrap
    cyc(0, 1, 0, 0, 0, 0, 3'd1, 16'hFFFF, 3'd0);
    cyc(0, 0, 0, 1, 0, 0, 3'd1, 16'h0, 3'd1);
    chk(0, F_ZERO, 16'h0, "pre_inc_zero");
    cyc(0, 0, 1, 0, 0, 0, 3'd1, 16'h0, 3'd1);
    chk(0, F_OUT, INCDEC ? 16'h0000 : 16'hFFFF, "inc_wrap_out");
    chk(0, F_ZERO, INCDEC ? 16'h1 : 16'h0, "inc_wrap_zero");
    chk(0, F_WRAP, INCDEC ? 16'h1 : 16'h0, "inc_wrap_flag");
    cyc(0, 0, 1, 0, 0, 1, 3'd1, 16'h0, 3'd1);
    cyc(0, 0, 0, 0, 1, 0, 3'd1, 16'h0, 3'd1);
    chk(0, F_WRAP, 16'h0, "clr_wrap");
    cyc(0, 0, 1, 0, 0, 0, 3'd1, 16'h0, 3'd1);
    chk(0, F_OUT, 16'hFFFF, "dec_wrap_out");
    chk(0, F_WRAP, INCDEC ? 16'h1 : 16'h0, "dec_wrap_flag");
    cyc(0, 0, 0, 0, 0, 1, 3'd1, 16'h0, 3'd1);
    cyc(0, 0, 0, 1, 0, 1, 3'd1, 16'h0, 3'd1);
    chk(0, F_WRAP, 16'h0, "clr_again");
    cyc(0, 0, 1, 0, 0, 0, 3'd1, 16'h0, 3'd1);
    chk(0, F_OUT, INCDEC ? 16'h0000 : 16'hFFFF, "set_over_clr_out");
    chk(0, F_WRAP, INCDEC ? 16'h1 : 16'h0, "set_over_clr_flag");
    chk(0, F_ERR, 16'h0, "no_err_yet");
    cyc(0, 0, 0, 0, 0, 1, 3'd1, 16'h0, 3'd1);

    // Priority
    cyc(0, 1, 0, 1, 0, 0, 3'd0, 16'h0010, 3'd0);
    chk(0, F_WRAP, 16'h0, "wrap_cleared");
    cyc(0, 0, 0, 1, 1, 0, 3'd0, 16'h0, 3'd0);
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0, 3'd0);
    chk(0, F_OUT, 16'h0010, "we_over_inc_incdec_both");
    cyc(0, 1, 1, 0, 0, 0, 3'd0, 16'h1234, 3'd0);
    chk(0, F_OUT, 16'h0, "conflict_out");
    chk(0, F_DISP, 16'h0010, "conflict_disp");
    chk(0, F_ERR, 16'h0, "conflict_err_before");
    cyc(0, 0, 1, 0, 0, 0, 3'd0, 16'h0, 3'd0);
    chk(0, F_OUT, 16'h0010, "conflict_no_write");
    chk(0, F_ERR, 16'h1, "conflict_err");

    // Out of range on the 6-register instance
    cyc(1, 0, 0, 0, 0, 0, 3'd0, 16'h0, 3'd0);
    cyc(0, 1, 0, 0, 0, 0, 3'd6, 16'h7777, 3'd5);
    chk(1, F_ERR, 16'h0, "oor_err_before");
    cyc(0, 0, 1, 0, 0, 0, 3'd7, 16'h0, 3'd6);
    chk(1, F_OUT, 16'h0, "oor_out");
    chk(1, F_ZERO, 16'h0, "oor_zero");
    chk(1, F_DISP, 16'h0, "oor_disp");
    chk(1, F_ERR, 16'h1, "oor_err");
    chk(0, F_DISP, 16'h7777, "main_r6_written");
    chk(0, F_ERR, 16'h0, "main_no_err");
    cyc(0, 0, 1, 0, 0, 0, 3'd5, 16'h0, 3'd0);
    chk(1, F_OUT, 16'h0, "oor_r5_unchanged");
    chk(1, F_ZERO, 16'h1, "oor_r5_zero");

    // Reset mid-sequence
    cyc(0, 1, 1, 0, 0, 0, 3'd0, 16'h5555, 3'd5);
    cyc(0, 0, 0, 1, 0, 0, 3'd5, 16'h0, 3'd5);
    chk(0, F_ERR, 16'h1, "pre_reset_err");
    cyc(1, 0, 0, 1, 0, 0, 3'd5, 16'h0, 3'd5);
    chk(0, F_DISP, INCDEC ? 16'h0001 : 16'h0000, "inc_before_reset");
    cyc(0, 0, 0, 1, 0, 0, 3'd5, 16'h0, 3'd5);
    chk(0, F_DISP, 16'h0000, "after_reset_r5");
    chk(0, F_ERR, 16'h0, "after_reset_err");
    cyc(0, 0, 1, 0, 0, 0, 3'd5, 16'h0, 3'd5);
    chk(0, F_OUT, INCDEC ? 16'h0001 : 16'h0000, "mid_reset_r5");
    chk(0, F_ZERO, INCDEC ? 16'h0 : 16'h1, "mid_reset_zero");
    chk(0, F_WRAP, 16'h0, "mid_reset_wrap");
    chk(0, F_ERR, 16'h0, "mid_reset_err");

    cyc(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 3'd0);
    @(posedge clk);
    #6;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
